// File: rtl/memory_bank_pkg.sv
// rtl/memory_bank_pkg.sv - size encodings, FSM states and boot image for memory_bank
package memory_bank_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [31:0] BOOT_W0 = 32'h002F000C;
    localparam logic [31:0] BOOT_W1 = 32'h001F000C;
    localparam logic [31:0] BOOT_W2 = 32'h13221000;
    localparam logic [31:0] BOOT_W3 = 32'h26FFFFF8;
    localparam logic [31:0] BOOT_W4 = 32'h00000000;
    localparam logic [31:0] BOOT_W5 = 32'h00000001;

    // Big-endian: byte 0 of each word is its most-significant byte.
    function automatic logic [7:0] boot_byte(input int a);
        logic [31:0] w;
        w = 32'h0;
        case (a / 4)
            0: w = BOOT_W0;
            1: w = BOOT_W1;
            2: w = BOOT_W2;
            3: w = BOOT_W3;
            4: w = BOOT_W4;
            5: w = BOOT_W5;
            default: w = 32'h0;
        endcase
        boot_byte = w[8 * (3 - (a % 4)) +: 8];
    endfunction

endpackage

// File: rtl/memory_bank_chk.sv
// rtl/memory_bank_chk.sv - combinational size/alignment/range checker
module memory_bank_chk
    import memory_bank_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 32
) (
    input  logic [1:0]    size,
    input  logic [AW-1:0] abus,
    output logic          err_next,
    output logic [2:0]    nbytes
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic          misalign;
    logic [AW:0]   end_addr;

    always_comb begin
        nbytes   = 3'd0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: begin
                nbytes   = 3'd2;
                misalign = abus[0];
            end
            SZ_WORD: begin
                nbytes   = 3'd4;
                misalign = |abus[1:0];
            end
            default: nbytes = 3'd0;
        endcase
        // One extra bit so addresses near the top of abus cannot wrap past the check.
        end_addr = {1'b0, abus} + {{(AW - 2){1'b0}}, nbytes};
        err_next = (size == SZ_RSVD) | misalign | (end_addr > DEPTH_W);
    end

endmodule

// File: rtl/memory_bank.sv
// rtl/memory_bank.sv - big-endian byte-array memory with wait states and error reporting
module memory_bank
    import memory_bank_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int BOOT_EN     = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          rw,
    input  logic [1:0]    size,
    input  logic [AW-1:0] abus,
    input  logic [31:0]   dbus_in,
    output logic [31:0]   dbus_out,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t          state, state_next;
    logic [3:0]      cnt;
    logic            rw_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic            err_q;
    logic [7:0]      mem [DEPTH];

    logic            chk_err;
    logic [2:0]      nbytes;
    logic [IW-1:0]   idx [4];
    logic [5:0]      shamt;
    logic [31:0]     raw_word;
    logic [31:0]     rd_data;
    logic [31:0]     wr_word;

    memory_bank_chk #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_chk (
        .size     (size_q),
        .abus     (addr_q),
        .err_next (chk_err),
        .nbytes   (nbytes)
    );

    // Always fetch four bytes, then right-justify by the access size; write
    // data is left-justified so lane k always lands on m[addr+k].
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = addr_q[IW-1:0] + IW'(k);
        end
        shamt    = {3'd4 - nbytes, 3'b000};
        raw_word = {mem[idx[0]], mem[idx[1]], mem[idx[2]], mem[idx[3]]};
        rd_data  = raw_word >> shamt;
        wr_word  = data_q << shamt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ack        = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (en) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt == 4'd0) state_next = ST_DONE;
            end
            ST_DONE: begin
                ack        = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
        err = ack & err_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            rw_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            addr_q   <= '0;
            data_q   <= 32'h0;
            err_q    <= 1'b0;
            dbus_out <= 32'h0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= (BOOT_EN != 0) ? boot_byte(k) : 8'h00;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        rw_q   <= rw;
                        size_q <= size;
                        addr_q <= abus;
                        data_q <= dbus_in;
                        cnt    <= 4'(WAIT_CYCLES);
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q <= chk_err;
                        if (!chk_err) begin
                            if (rw_q) begin
                                dbus_out <= rd_data;
                            end else begin
                                for (int k = 0; k < 4; k++) begin
                                    if (3'(k) < nbytes) mem[idx[k]] <= wr_word[31 - 8 * k -: 8];
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_bank.md
MEMORY_BANK -- requirements
Module: memory_bank

Interface
REQ-001 Parameter DEPTH, default 128, SHALL set the array size in bytes; legal byte addresses are 0..DEPTH-1.
REQ-002 Parameter AW, default 32, SHALL set the abus width.
REQ-003 Parameter WAIT_CYCLES, default 2, range 0..15, SHALL set the wait states inserted per access.
REQ-004 Parameter BOOT_EN, default 1, SHALL select whether the boot image is loaded on reset (1) or the array is cleared to 0 (0).
REQ-005 clock  in  1  sole clock, rising-edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  request valid.
REQ-008 rw  in  1  1 = read, 0 = write.
REQ-009 size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 abus  in  AW  byte address.
REQ-011 dbus_in  in  32  write data, right-justified for byte and half accesses.
REQ-012 dbus_out  out  32  read data, registered.
REQ-013 ack  out  1  one-cycle completion pulse.
REQ-014 err  out  1  error flag, valid only while ack=1.
REQ-015 busy  out  1  high from request acceptance until the ack cycle inclusive.

Function
REQ-016 The block SHALL be a byte array with big-endian packing: byte m[a] maps to the most-significant byte of the accessed unit.
REQ-017 The FSM SHALL have three states: IDLE, WAIT, DONE.
  - IDLE: en=1 at a rising edge latches rw, size, abus and dbus_in, loads cnt=WAIT_CYCLES, and moves to WAIT.
  - WAIT: cnt>0 decrements cnt; cnt=0 performs the access at that edge and moves to DONE.
  - DONE: ack=1 for this one cycle; the next edge returns to IDLE unconditionally.
REQ-018 Latency SHALL be WAIT_CYCLES+2 edges from acceptance to ack-high, with peak throughput of one access per WAIT_CYCLES+3 cycles.
REQ-019 en and all request inputs SHALL be ignored in WAIT and DONE; the latched copies are used.
REQ-020 A read SHALL zero-extend into dbus_out: byte into [7:0], half into [15:0].
REQ-021 A write SHALL store only size bytes taken from the low end of dbus_in.
REQ-022 dbus_out SHALL change only on a successful read completion and SHALL hold its value otherwise.
REQ-023 err=1 SHALL be raised, with no array change and dbus_out held, for any of:
  - size=11;
  - a halfword at an odd address;
  - a word at an address not a multiple of 4;
  - abus+bytes > DEPTH, including upper address bits beyond DEPTH.
REQ-024 No wrap-around SHALL occur: the last legal word is at DEPTH-4, and a word at DEPTH-2 is an error.
REQ-025 en held high continuously SHALL produce back-to-back accesses, each accepted in IDLE.

Reset
REQ-026 reset low SHALL force state=IDLE, cnt=0, ack=0, err=0, busy=0 and dbus_out=0 immediately, independent of clock.
REQ-027 With BOOT_EN=1, reset SHALL load words at byte addresses 0x00..0x14 as 002F000C, 001F000C, 13221000, 26FFFFF8, 00000000, 00000001, with all other bytes 0.
REQ-028 Reset asserted during WAIT SHALL abort the access: no write occurs and no ack is issued after release.
REQ-029 The first request SHALL be accepted no earlier than the first rising edge after reset deasserts.

Structure
REQ-030 Package memory_bank_pkg SHALL hold the size encodings, the FSM state encoding and the six boot-image constants.
REQ-031 Sub-module memory_bank_chk SHALL be the combinational address/alignment/range checker producing err_next and the byte count.
REQ-032 The array, FSM and data path SHALL reside in memory_bank; there SHALL be no tri-state outputs.

Verification
REQ-033 Boot readback: reset, then word reads at 0x00, 0x08, 0x14 -> dbus_out = 002F000C, 13221000, 00000001, err=0, each ack exactly WAIT_CYCLES+2 edges after acceptance.
REQ-034 Byte/half write: byte write 0x3A to 0x05, then word read at 0x04 -> 003A000C; half write 0xBEEF to 0x06, then word read at 0x04 -> 003ABEEF; byte read at 0x06 -> 000000BE.
REQ-035 Errors: word at 0x02, half at 0x03, size=11, word at DEPTH-2 (0x7E) -> ack with err=1; a following read of 0x00 -> 002F000C and unchanged dbus_out in between.
REQ-036 Ignored input: change abus/dbus_in/en during WAIT -> access uses the originally latched values; en held high for 3 requests -> 3 ack pulses spaced WAIT_CYCLES+3 cycles apart.
REQ-037 Reset mid-operation: word write 0xDEADBEEF to 0x40, assert reset in WAIT -> no ack; read 0x40 after release -> 00000000.
REQ-038 Parameter sweep: WAIT_CYCLES=0 and 15, DEPTH=256 -> latency 2 and 17 edges; word at 0xFC legal, word at 0x100 -> err=1.
